scaler_readout_sched: RTL and testbench
=======================================

Name: scaler_readout_sched

Overview:
- Sequencer for a bank of P_N_CHAN discriminator scalers. Each scaler emits one count per counting window.
- The block snapshots each channel's count on its window-update pulse and marks it pending.
- Pending snapshots are served one at a time onto a shared valid/ready readout port, using round-robin arbitration.
- The block also owns the common window-period register. Any period write re-aligns all scalers by pulsing their reset.

Parameters:
- P_N_CHAN, 4, number of scaler channels (2..16)
- P_N_WIDTH, 32, scaler count width
- P_RST_CYC, 4, length in clk cycles of scaler reset pulse after a period write (≥2)
- P_PERIOD_DEF, 1000, power-on/reset value of period_out

Ports:
- clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- period_in  in  P_N_WIDTH  new window period
- period_wr  in  1  one-cycle strobe: load period_in
- period_out  out  P_N_WIDTH  period driven to all scalers
- scaler_rst  out  1  reset to all scalers
- sc_update  in  P_N_CHAN  per-channel window-update pulse
- sc_count  in  P_N_CHAN*P_N_WIDTH  per-channel count; channel k occupies bits [k*W +: W]
- out_valid  out  1  readout word valid
- out_ready  in  1  consumer accepts word
- out_chan  out  4  channel index of word
- out_count  out  P_N_WIDTH  snapshot count
- out_sat  out  1  out_count == all ones (saturated/overflowed window)
- out_overrun  out  1  ≥1 window of this channel lost before this word
- overrun_any  out  1  sticky OR of all overrun events since reset

Behaviour:
- Reset: i_rst, synchronous, active-high; clock clk. All outputs are 0 except period_out=P_PERIOD_DEF. Reset clears pending, overrun, snapshots, RR pointer (=P_N_CHAN-1) and the flush counter.
- Capture: on sc_update[k]=1, snap[k]<=sc_count[k] and pending[k]<=1 next cycle.
  - If pending[k] was already 1 and is not being granted that cycle, ovr[k]<=1 (old snapshot overwritten).
  - If pending[k] is granted the same cycle, the old value goes out, the new value is captured, pending stays 1, and there is no overrun.
- FSM IDLE: if flush_cnt==0 and any pending, grant the first pending channel searching from rr_ptr+1 upward with wrap.
  - Load out_chan/out_count/out_sat/out_overrun from that channel.
  - Clear its pending and ovr, set rr_ptr=grant, go to PRESENT.
- FSM PRESENT: out_valid=1. All out_* are held stable until out_ready=1, then return to IDLE with out_valid=0 next cycle.
  - Maximum throughput is 1 word / 2 cycles.
  - out_valid never drops without a handshake.
- Period write: period_wr=1 gives period_out<=period_in next cycle, even if the value is unchanged.
  - flush_cnt<=P_RST_CYC; scaler_rst=1 while flush_cnt≠0.
  - During flush, pending and ovr are cleared every cycle and sc_update is ignored.
  - A word already in PRESENT is unaffected and completes normally.
- period_wr during flush: period is reloaded and flush_cnt restarts at P_RST_CYC.
- period_wr coincident with sc_update: the flush wins and the capture is dropped.
- overrun_any: set on any ovr event; cleared only by i_rst.
- No clamping of period_out; scalers apply their own minimum.

Test Plan:
- Single channel: P_N_CHAN=4. sc_update[2] with count 0x1234, out_ready=1.
  - Expect one word: chan=2, count=0x1234, sat=0, overrun=0.
  - out_valid high for exactly 1 cycle, beginning 2 cycles after the update.
- Round robin: updates on ch0..3 in the same cycle with counts 10,11,12,13, out_ready=1.
  - Expect words in order 0,1,2,3.
  - Then updates on ch0 and ch3 together: expect order 0,3 (pointer last=3 → ch0 first).
- Backpressure/overrun: ch1 count 5, hold out_ready=0, then ch1 update count 7, then ch1 update count 9.
  - Word for ch1 (count 5) stays stable while stalled.
  - After release: next ch1 word has count 9, overrun=1; overrun_any=1.
- Coincident grant/update: ch0 update lands the same cycle ch0 is granted.
  - Expect two ch0 words, both overrun=0.
- Saturation: sc_count=0xFFFFFFFF on ch3 → out_sat=1.
- Period write: period_wr with 500 while ch1 pending and ch2 word presented.
  - period_out=500 next cycle; scaler_rst high exactly 4 cycles.
  - Ch2 word still delivered; ch1 discarded; updates during flush ignored.
  - Reset mid-PRESENT: out_valid=0 next cycle, period_out=1000.

Source files
------------

// File: rtl/scaler_readout_sched.sv
// Scaler readout sequencer: snapshots per-channel window counts and serves
// them round-robin onto a valid/ready port; owns the shared window period.
module scaler_readout_sched #(
    parameter int P_N_CHAN     = 4,
    parameter int P_N_WIDTH    = 32,
    parameter int P_RST_CYC    = 4,
    parameter int P_PERIOD_DEF = 1000
) (
    input  logic                            clk,
    input  logic                            i_rst,
    input  logic [P_N_WIDTH-1:0]            period_in,
    input  logic                            period_wr,
    output logic [P_N_WIDTH-1:0]            period_out,
    output logic                            scaler_rst,
    input  logic [P_N_CHAN-1:0]             sc_update,
    input  logic [P_N_CHAN*P_N_WIDTH-1:0]   sc_count,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [3:0]                      out_chan,
    output logic [P_N_WIDTH-1:0]            out_count,
    output logic                            out_sat,
    output logic                            out_overrun,
    output logic                            overrun_any
);

    localparam int FW = $clog2(P_RST_CYC + 1);

    typedef enum logic {
        S_IDLE,
        S_PRESENT
    } state_t;

    state_t                 state_q, state_d;
    logic [P_N_CHAN-1:0]    pending_q, pending_d;
    logic [P_N_CHAN-1:0]    ovr_q, ovr_d;
    logic [P_N_WIDTH-1:0]   snap_q [P_N_CHAN];
    logic [P_N_WIDTH-1:0]   snap_d [P_N_CHAN];
    logic [3:0]             rr_ptr_q, rr_ptr_d;
    logic [FW-1:0]          flush_cnt_q, flush_cnt_d;
    logic [P_N_WIDTH-1:0]   period_q, period_d;
    logic                   out_valid_q, out_valid_d;
    logic [3:0]             out_chan_q, out_chan_d;
    logic [P_N_WIDTH-1:0]   out_count_q, out_count_d;
    logic                   out_sat_q, out_sat_d;
    logic                   out_overrun_q, out_overrun_d;
    logic                   overrun_any_q, overrun_any_d;

    logic                   found;
    logic [3:0]             gnt_idx;
    int                     j;
    logic                   flush_busy;
    logic                   block_cap;
    logic                   do_grant;
    logic [P_N_CHAN-1:0]    grant_vec;
    logic [P_N_CHAN-1:0]    ovr_evt;
    logic [P_N_WIDTH-1:0]   sel_snap;
    logic                   sel_ovr;

    // First pending channel strictly after the last grant, with wrap.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int i = 1; i <= P_N_CHAN; i++) begin
            j = (int'(rr_ptr_q) + i) % P_N_CHAN;
            if (!found && pending_q[j]) begin
                found   = 1'b1;
                gnt_idx = 4'(j);
            end
        end
    end

    assign flush_busy = (flush_cnt_q != '0);
    assign block_cap  = flush_busy || period_wr;
    assign do_grant   = (state_q == S_IDLE) && !flush_busy && found;

    always_comb begin
        grant_vec = '0;
        sel_snap  = '0;
        sel_ovr   = 1'b0;
        for (int k = 0; k < P_N_CHAN; k++) begin
            if (do_grant && (gnt_idx == 4'(k))) begin
                grant_vec[k] = 1'b1;
                sel_snap     = snap_q[k];
                sel_ovr      = ovr_q[k];
            end
        end
    end

    // A channel granted this cycle hands its old value out, so a fresh
    // update on it is not an overrun.
    assign ovr_evt = block_cap ? '0 : (sc_update & pending_q & ~grant_vec);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        out_valid_d   = out_valid_q;
        out_chan_d    = out_chan_q;
        out_count_d   = out_count_q;
        out_sat_d     = out_sat_q;
        out_overrun_d = out_overrun_q;
        period_d      = period_q;
        flush_cnt_d   = flush_cnt_q;
        overrun_any_d = overrun_any_q | (|ovr_evt);
        for (int k = 0; k < P_N_CHAN; k++) begin
            snap_d[k] = snap_q[k];
        end

        if (block_cap) begin
            pending_d = '0;
            ovr_d     = '0;
        end else begin
            pending_d = (pending_q & ~grant_vec) | sc_update;
            ovr_d     = (ovr_q & ~grant_vec) | ovr_evt;
            for (int k = 0; k < P_N_CHAN; k++) begin
                if (sc_update[k]) begin
                    snap_d[k] = sc_count[k*P_N_WIDTH +: P_N_WIDTH];
                end
            end
        end

        if (period_wr) begin
            period_d    = period_in;
            flush_cnt_d = FW'(P_RST_CYC);
        end else if (flush_busy) begin
            flush_cnt_d = flush_cnt_q - 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (do_grant) begin
                    out_valid_d   = 1'b1;
                    out_chan_d    = gnt_idx;
                    out_count_d   = sel_snap;
                    out_sat_d     = &sel_snap;
                    out_overrun_d = sel_ovr;
                    rr_ptr_d      = gnt_idx;
                    state_d       = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            pending_q     <= '0;
            ovr_q         <= '0;
            rr_ptr_q      <= 4'(P_N_CHAN - 1);
            flush_cnt_q   <= '0;
            period_q      <= P_N_WIDTH'(P_PERIOD_DEF);
            out_valid_q   <= 1'b0;
            out_chan_q    <= '0;
            out_count_q   <= '0;
            out_sat_q     <= 1'b0;
            out_overrun_q <= 1'b0;
            overrun_any_q <= 1'b0;
            for (int k = 0; k < P_N_CHAN; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            ovr_q         <= ovr_d;
            rr_ptr_q      <= rr_ptr_d;
            flush_cnt_q   <= flush_cnt_d;
            period_q      <= period_d;
            out_valid_q   <= out_valid_d;
            out_chan_q    <= out_chan_d;
            out_count_q   <= out_count_d;
            out_sat_q     <= out_sat_d;
            out_overrun_q <= out_overrun_d;
            overrun_any_q <= overrun_any_d;
            for (int k = 0; k < P_N_CHAN; k++) begin
                snap_q[k] <= snap_d[k];
            end
        end
    end

    assign period_out  = period_q;
    assign scaler_rst  = flush_busy;
    assign out_valid   = out_valid_q;
    assign out_chan    = out_chan_q;
    assign out_count   = out_count_q;
    assign out_sat     = out_sat_q;
    assign out_overrun = out_overrun_q;
    assign overrun_any = overrun_any_q;

endmodule

// File: tb/tb_scaler_readout_sched.sv
// Scoreboard bench for scaler_readout_sched: expected words are queued as
// stimulus is applied and compared at each readout handshake.
module tb_scaler_readout_sched;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        logic [3:0]   chan;
        logic [W-1:0] cnt;
        logic         sat;
        logic         ovr;
    } exp_t;

    logic             clk = 1'b0;
    logic             i_rst;
    logic [W-1:0]     period_in;
    logic             period_wr;
    logic [W-1:0]     period_out;
    logic             scaler_rst;
    logic [N-1:0]     sc_update;
    logic [N*W-1:0]   sc_count;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_chan;
    logic [W-1:0]     out_count;
    logic             out_sat;
    logic             out_overrun;
    logic             overrun_any;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    scaler_readout_sched #(
        .P_N_CHAN(N), .P_N_WIDTH(W), .P_RST_CYC(4), .P_PERIOD_DEF(1000)
    ) dut (
        .clk(clk), .i_rst(i_rst),
        .period_in(period_in), .period_wr(period_wr),
        .period_out(period_out), .scaler_rst(scaler_rst),
        .sc_update(sc_update), .sc_count(sc_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_chan(out_chan), .out_count(out_count),
        .out_sat(out_sat), .out_overrun(out_overrun),
        .overrun_any(overrun_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [W-1:0] c,
                        input logic s, input logic o);
        exp_t e;
        e.chan = 4'(ch);
        e.cnt  = c;
        e.sat  = s;
        e.ovr  = o;
        q.push_back(e);
    endtask

    task automatic upd(input int ch, input logic [W-1:0] c);
        sc_update[ch]          = 1'b1;
        sc_count[ch*W +: W]    = c;
        tick();
        sc_update = '0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, W'(q.size()), '0);
    endtask

    // Handshake happens at the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (!i_rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_word", W'(out_chan), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("chan", W'(out_chan), W'(e.chan));
                chk("count", out_count, e.cnt);
                chk("sat", W'(out_sat), W'(e.sat));
                chk("overrun", W'(out_overrun), W'(e.ovr));
            end
        end
    end

    initial begin
        int nrst;
        i_rst     = 1'b1;
        period_in = '0;
        period_wr = 1'b0;
        sc_update = '0;
        sc_count  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", W'(out_valid), '0);
        chk("rst_period", period_out, 32'd1000);
        chk("rst_srst", W'(scaler_rst), '0);
        chk("rst_ovany", W'(overrun_any), '0);
        i_rst = 1'b0;

        // Single word latency and width of valid
        out_ready = 1'b1;
        push(2, 32'h1234, 1'b0, 1'b0);
        upd(2, 32'h1234);
        chk("lat_v0", W'(out_valid), '0);
        tick();
        chk("lat_v1", W'(out_valid), 32'd1);
        tick();
        chk("lat_v2", W'(out_valid), '0);
        drain("drain_single");

        // Round robin from a fresh pointer
        do_reset();
        for (int k = 0; k < N; k++) begin
            push(k, 32'(10 + k), 1'b0, 1'b0);
            sc_count[k*W +: W] = 32'(10 + k);
        end
        sc_update = '1;
        tick();
        sc_update = '0;
        drain("drain_rr");
        push(0, 32'd20, 1'b0, 1'b0);
        push(3, 32'd23, 1'b0, 1'b0);
        sc_count[0 +: W]   = 32'd20;
        sc_count[3*W +: W] = 32'd23;
        sc_update = 4'b1001;
        tick();
        sc_update = '0;
        drain("drain_rr2");

        // Backpressure and overrun
        do_reset();
        out_ready = 1'b0;
        push(1, 32'd5, 1'b0, 1'b0);
        push(1, 32'd9, 1'b0, 1'b1);
        upd(1, 32'd5);
        tick();
        upd(1, 32'd7);
        upd(1, 32'd9);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", W'(out_valid), 32'd1);
            chk("stall_count", out_count, 32'd5);
            tick();
        end
        chk("ovany_set", W'(overrun_any), 32'd1);
        out_ready = 1'b1;
        drain("drain_bp");
        chk("ovany_sticky", W'(overrun_any), 32'd1);

        // Update lands on the same cycle its channel is granted
        do_reset();
        chk("ovany_clr", W'(overrun_any), '0);
        push(0, 32'd20, 1'b0, 1'b0);
        push(0, 32'd21, 1'b0, 1'b0);
        upd(0, 32'd20);
        upd(0, 32'd21);
        drain("drain_coinc");

        // Saturated count
        push(3, 32'hFFFF_FFFF, 1'b1, 1'b0);
        upd(3, 32'hFFFF_FFFF);
        drain("drain_sat");

        // Period write while one word presented and another pending
        do_reset();
        out_ready = 1'b0;
        push(2, 32'h22, 1'b0, 1'b0);
        upd(2, 32'h22);
        tick();
        chk("pw_valid", W'(out_valid), 32'd1);
        chk("pw_chan", W'(out_chan), 32'd2);
        upd(1, 32'h11);
        period_in = 32'd500;
        period_wr = 1'b1;
        sc_update[3] = 1'b1;
        sc_count[3*W +: W] = 32'h33;
        tick();
        period_wr = 1'b0;
        sc_update = '0;
        chk("pw_period", period_out, 32'd500);
        nrst = 0;
        for (int i = 0; i < 8; i++) begin
            if (scaler_rst) nrst++;
            if (i < 3) sc_update[1] = 1'b1;
            tick();
            sc_update = '0;
        end
        chk("pw_rst_cycles", W'(nrst), 32'd4);
        chk("pw_hold_valid", W'(out_valid), 32'd1);
        chk("pw_hold_count", out_count, 32'h22);
        out_ready = 1'b1;
        drain("drain_pw");
        repeat (10) tick();
        chk("pw_idle", W'(out_valid), '0);
        chk("pw_period_keep", period_out, 32'd500);

        // Reset while a word is presented
        out_ready = 1'b0;
        upd(0, 32'h44);
        tick();
        chk("mid_valid", W'(out_valid), 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("mid_rst_valid", W'(out_valid), '0);
        chk("mid_rst_period", period_out, 32'd1000);
        chk("mid_rst_count", out_count, '0);
        repeat (5) tick();
        chk("mid_rst_idle", W'(out_valid), '0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
